basilisk_add_align: RTL
=======================

BASILISK_ADD_ALIGN -- requirements
Module: basilisk_add_align

Interface
REQ-001 SHALL have parameter OUTPUT_REGISTER_MODE, default 1, selecting the registered (1) or pass-through (0) output std_flow_stage.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port add_command, std_stream_intf.in, payload 73 bits: {a[31:0], b[31:0], op (0 add, 1 sub), rm[2:0], id[4:0]}, with valid/ready.
REQ-005 SHALL have port add_operation_command, std_stream_intf.out, payload fpu_add_op_result_t, 49 bits: {sign, exp[7:0], mant[27:0], nan, inf, zero, invalid, rm[2:0], id[4:0]}, with valid/ready; the port feeds basilisk_add_normalize.

Function
REQ-006 SHALL implement two internal pipeline stages: S1 (unpack/classify/compare/swap) and S2 (align/add); the output stage follows S2.
REQ-007 SHALL have a minimum latency of 2 cycles from input handshake to output valid, with OUTPUT_REGISTER_MODE=0.
REQ-008 SHALL sustain 1 operation per cycle with no backpressure.
REQ-009 SHALL load each stage only when that stage is empty or its contents advance in the same cycle (bubble collapse).
REQ-010 SHALL drive add_command.ready = S1 empty or S1 advancing.
REQ-011 SHALL transfer data only on valid&&ready, never drop or duplicate an operation, and preserve order.
REQ-012 SHALL hold the output payload stable while output valid is high and ready is low.
REQ-013 SHALL unpack each operand so that exp==0 gives hidden bit 0 and effective exponent 1; otherwise hidden bit 1.
REQ-014 SHALL use effective b sign = b[31] ^ op.
REQ-015 SHALL select L as the larger magnitude by {exp,frac} unsigned compare, choosing a on a tie; S is the other operand.
REQ-016 SHALL place mantissa layout as bit27 carry, bit26 hidden, bits25:3 fraction, bits2:0 guard/round/sticky.
REQ-017 SHALL compute diff = effexpL - effexpS and right-shift S's mantissa by diff.
REQ-018 SHALL set sticky (bit0) to the OR of all bits shifted out; diff>=27 gives shifted mantissa 0 with sticky = OR of S mantissa.
REQ-019 SHALL output mant = mL + mS when effective signs are equal, else mL - mS (never negative given the swap).
REQ-020 SHALL output exp = L's effective exponent and sign = L's effective sign.
REQ-021 SHALL, on an exact-zero result, set zero=1 and mant=0, with sign = 1 only when rm==3'b010 (RDN) for differing signs, else the common sign.
REQ-022 SHALL set nan=1 if either input is NaN, and invalid=1 if either is sNaN.
REQ-023 SHALL set nan=1 and invalid=1 when inf and inf have opposite effective signs.
REQ-024 SHALL, when exactly one input is inf or both are inf with the same effective sign, set inf=1 with that sign.
REQ-025 SHALL propagate rm and id unchanged.

Reset
REQ-026 SHALL, while rst is low, clear all stage valids asynchronously and force add_operation_command.valid=0 and add_command.ready=0.
REQ-027 SHALL discard any in-flight operations on reset; none emerge after release.
REQ-028 SHALL drive add_command.ready=1 on the first clk edge after rst deasserts.
REQ-029 SHALL leave payload registers undefined-allowed (not reset).

Verification
REQ-030 SHALL pass this case: a=0x3F800000, b=0x3F800000, op=0 -> sign 0, exp 127, mant 0x8000000, flags 0.
REQ-031 SHALL pass this case: a=0x3F800000, b=0x3F800000, op=1, rm=0 -> zero=1, sign 0, mant 0; with rm=2 -> zero=1, sign 1.
REQ-032 SHALL pass this case: a=0x3F800000, b=0x30800000 (diff 30), op=0 -> exp 127, mant 0x4000001 (sticky only).
REQ-033 SHALL pass this case: a=0x7F800000, b=0x7F800000, op=1 -> nan=1, invalid=1; a=0x7F800001 (sNaN) + 1.0 -> nan=1, invalid=1.
REQ-034 SHALL pass this backpressure case: 4 back-to-back ops with output ready low for 5 cycles -> input ready falls once the pipeline is full; after ready returns, all 4 results appear in order, ids intact, payloads stable while stalled.
REQ-035 SHALL pass this reset case: rst pulsed low with 2 ops in flight -> output valid 0 immediately, no stale result after release, and the next op completes with correct latency.

Source files
------------

// File: rtl/basilisk_add_align_if.sv
// Generic valid/ready stream carrying a WIDTH-bit payload; "in" faces the
// consumer of the stream and "out" faces its producer.
interface std_stream_intf #(
    parameter int WIDTH = 8
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport in  (input valid, input data, output ready);
    modport out (output valid, output data, input ready);
endinterface

// File: rtl/basilisk_add_align.sv
// FP32 add/sub front end: unpack, classify, order the operands by magnitude,
// align the smaller one and add/subtract, feeding basilisk_add_normalize.
module basilisk_add_align #(
    parameter int OUTPUT_REGISTER_MODE = 1
) (
    input  logic           clk,
    input  logic           rst,
    std_stream_intf.in     add_command,
    std_stream_intf.out    add_operation_command
);

    typedef struct packed {
        logic        sign;
        logic [7:0]  eexp;
        logic [23:0] mant;
        logic        nan;
        logic        snan;
        logic        inf;
    } opnd_t;

    typedef struct packed {
        logic        sign_l;
        logic        eff_sub;
        logic [7:0]  exp_l;
        logic [7:0]  exp_s;
        logic [23:0] mant_l;
        logic [23:0] mant_s;
        logic        nan;
        logic        inf;
        logic        inf_sign;
        logic        invalid;
        logic [2:0]  rm;
        logic [4:0]  id;
    } s1_t;

    function automatic opnd_t unpack(input logic [31:0] f, input logic flip);
        opnd_t o;
        o.sign = f[31] ^ flip;
        o.eexp = (f[30:23] == 8'd0) ? 8'd1 : f[30:23];
        o.mant = {(f[30:23] != 8'd0), f[22:0]};
        o.nan  = (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
        o.snan = o.nan && !f[22];
        o.inf  = (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
        return o;
    endfunction

    logic [31:0] a_s, b_s;
    logic        op_s;
    logic [2:0]  rm_s;
    logic [4:0]  id_s;
    opnd_t       opa_s, opb_s, big_s, small_s;
    logic        a_ge_s, inf_clash_s;
    s1_t         s1_next_s, s1_r;

    logic        rst_done_r, s1_valid_r, s2_valid_r;
    logic        out_take_s, s2_can_load_s, s1_can_load_s, in_fire_s;
    logic [48:0] s2_next_s, s2_data_r;

    logic [27:0] ext_l_s, ext_s_s, shifted_s, aligned_s, sum_s;
    logic [7:0]  diff_s;
    logic        sticky_s, zero_s, sign_s;

    assign {a_s, b_s, op_s, rm_s, id_s} = add_command.data;
    assign opa_s  = unpack(a_s, 1'b0);
    assign opb_s  = unpack(b_s, op_s);
    assign a_ge_s = (a_s[30:0] >= b_s[30:0]);

    // S1: classify specials and order operands so the larger magnitude leads
    always_comb begin
        s1_next_s   = '0;
        big_s       = a_ge_s ? opa_s : opb_s;
        small_s     = a_ge_s ? opb_s : opa_s;
        inf_clash_s = opa_s.inf && opb_s.inf && (opa_s.sign != opb_s.sign);
        s1_next_s.sign_l   = big_s.sign;
        s1_next_s.eff_sub  = (opa_s.sign != opb_s.sign);
        s1_next_s.exp_l    = big_s.eexp;
        s1_next_s.exp_s    = small_s.eexp;
        s1_next_s.mant_l   = big_s.mant;
        s1_next_s.mant_s   = small_s.mant;
        s1_next_s.nan      = opa_s.nan || opb_s.nan || inf_clash_s;
        s1_next_s.invalid  = opa_s.snan || opb_s.snan || inf_clash_s;
        s1_next_s.inf      = !s1_next_s.nan && (opa_s.inf || opb_s.inf);
        s1_next_s.inf_sign = opa_s.inf ? opa_s.sign : opb_s.sign;
        s1_next_s.rm       = rm_s;
        s1_next_s.id       = id_s;
    end

    // S2: right-align the smaller mantissa (sticky keeps shifted-out bits) and add
    always_comb begin
        ext_l_s = {1'b0, s1_r.mant_l, 3'b000};
        ext_s_s = {1'b0, s1_r.mant_s, 3'b000};
        diff_s  = s1_r.exp_l - s1_r.exp_s;
        if (diff_s >= 8'd27) begin
            shifted_s = 28'd0;
            sticky_s  = |ext_s_s;
        end else begin
            shifted_s = ext_s_s >> diff_s;
            sticky_s  = |(ext_s_s & ((28'd1 << diff_s) - 28'd1));
        end
        aligned_s = {shifted_s[27:1], shifted_s[0] | sticky_s};
        sum_s     = s1_r.eff_sub ? (ext_l_s - aligned_s) : (ext_l_s + aligned_s);
        zero_s    = (sum_s == 28'd0) && !s1_r.nan && !s1_r.inf;
        sign_s    = s1_r.inf ? s1_r.inf_sign :
                    (zero_s && s1_r.eff_sub) ? (s1_r.rm == 3'b010) : s1_r.sign_l;
        s2_next_s = {sign_s, s1_r.exp_l, sum_s, s1_r.nan, s1_r.inf, zero_s,
                     s1_r.invalid, s1_r.rm, s1_r.id};
    end

    assign s2_can_load_s     = !s2_valid_r || out_take_s;
    assign s1_can_load_s     = !s1_valid_r || s2_can_load_s;
    assign add_command.ready = rst_done_r && s1_can_load_s;
    assign in_fire_s         = add_command.valid && add_command.ready;

    // Input is held off until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_done_r <= 1'b0;
        end else begin
            rst_done_r <= 1'b1;
        end
    end

    // Stage occupancy; a stage refills only when empty or draining this cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (s1_can_load_s) s1_valid_r <= in_fire_s;
            if (s2_can_load_s) s2_valid_r <= s1_valid_r;
        end
    end

    // Stage payloads, not reset
    always_ff @(posedge clk) begin
        if (in_fire_s) s1_r <= s1_next_s;
        if (s2_can_load_s && s1_valid_r) s2_data_r <= s2_next_s;
    end

    generate
        if (OUTPUT_REGISTER_MODE != 0) begin : g_out_reg
            logic        out_valid_r;
            logic [48:0] out_data_r;

            assign out_take_s                 = !out_valid_r || add_operation_command.ready;
            assign add_operation_command.valid = out_valid_r;
            assign add_operation_command.data  = out_data_r;

            // Output skid register occupancy
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out_valid_r <= 1'b0;
                end else if (out_take_s) begin
                    out_valid_r <= s2_valid_r;
                end else begin
                    out_valid_r <= out_valid_r;
                end
            end

            // Output payload, held while stalled
            always_ff @(posedge clk) begin
                if (out_take_s && s2_valid_r) out_data_r <= s2_data_r;
            end
        end else begin : g_out_pass
            assign out_take_s                 = add_operation_command.ready;
            assign add_operation_command.valid = s2_valid_r;
            assign add_operation_command.data  = s2_data_r;
        end
    endgenerate

endmodule
